axi_bus_matrix_rr: RTL and testbench

- Parametrised N-master to 1-slave AXI-lite interconnect; successor to the 2-master fixed-priority read-only arbiter.
- Arbitrates both the read path (AR/R) and the write path (AW/W/B). The two paths are independent, and each uses round-robin arbitration.
- Sits between the core's bus masters (ifu, lsu, later dma/debug) and the single sram/peripheral slave port.
- Each path allows one outstanding transaction; the grant is held from grant until the response handshake.

---
 rtl/axi_bus_matrix_rr.sv | 207 ++++++++++++++++++++
 tb/tb_axi_bus_matrix_rr.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_bus_matrix_rr.sv
// rtl/axi_bus_matrix_rr.sv - N-master to 1-slave AXI-lite interconnect, independent round-robin read/write arbitration
// Define AXI_BUS_MATRIX_FIXED_PRIO_EN to drop the round-robin pointers and use fixed lowest-index priority.
module axi_bus_matrix_rr #(
    parameter int MASTER_NUM = 3,
    parameter int DATA_LEN   = 32,
    parameter int ADDR_LEN   = 32,
    parameter int STROB_LEN  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [MASTER_NUM-1:0]          m_arvalid,
    output logic [MASTER_NUM-1:0]          m_arready,
    input  logic [MASTER_NUM*ADDR_LEN-1:0] m_raddr,
    output logic [MASTER_NUM-1:0]          m_rvalid,
    input  logic [MASTER_NUM-1:0]          m_rready,
    output logic [MASTER_NUM*3-1:0]        m_rresp,
    output logic [MASTER_NUM*DATA_LEN-1:0] m_rdata,
    input  logic [MASTER_NUM-1:0]          m_awvalid,
    output logic [MASTER_NUM-1:0]          m_awready,
    input  logic [MASTER_NUM*ADDR_LEN-1:0] m_waddr,
    input  logic [MASTER_NUM-1:0]          m_wvalid,
    output logic [MASTER_NUM-1:0]          m_wready,
    input  logic [MASTER_NUM*STROB_LEN-1:0] m_strob,
    input  logic [MASTER_NUM*DATA_LEN-1:0] m_wdata,
    output logic [MASTER_NUM-1:0]          m_bvalid,
    input  logic [MASTER_NUM-1:0]          m_bready,
    output logic [MASTER_NUM*3-1:0]        m_bresp,
    output logic                           s_arvalid,
    input  logic                           s_arready,
    output logic [ADDR_LEN-1:0]            s_raddr,
    input  logic                           s_rvalid,
    output logic                           s_rready,
    input  logic [2:0]                     s_rresp,
    input  logic [DATA_LEN-1:0]            s_rdata,
    output logic                           s_awvalid,
    input  logic                           s_awready,
    output logic [ADDR_LEN-1:0]            s_waddr,
    output logic                           s_wvalid,
    input  logic                           s_wready,
    output logic [STROB_LEN-1:0]           s_strob,
    output logic [DATA_LEN-1:0]            s_wdata,
    input  logic                           s_bvalid,
    output logic                           s_bready,
    input  logic [2:0]                     s_bresp,
    output logic [MASTER_NUM-1:0]          rd_grant,
    output logic [MASTER_NUM-1:0]          wr_grant
);
    localparam int PW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_RESP} wr_state_t;

    rd_state_t rd_state, rd_state_next;
    wr_state_t wr_state, wr_state_next;
    logic [MASTER_NUM-1:0] rd_grant_next, wr_grant_next;
    logic [PW-1:0] rd_base, wr_base;
    logic aw_done, w_done;
    logic aw_hs, w_hs, r_hs, b_hs;

    // First requester at or after ptr, wrapping; lower k wins because it is assigned last.
    function automatic logic [MASTER_NUM-1:0] pick(input logic [MASTER_NUM-1:0] req,
                                                   input logic [PW-1:0] ptr);
        logic [MASTER_NUM-1:0] sel;
        logic [MASTER_NUM-1:0] oh;
        int idx;
        sel = '0;
        for (int k = MASTER_NUM - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % MASTER_NUM;
            oh  = {{(MASTER_NUM-1){1'b0}}, 1'b1} << idx;
            if ((req & oh) != '0) sel = oh;
        end
        return sel;
    endfunction

    // AND-OR muxes selecting the granted master's payload, chained over masters.
    logic [ADDR_LEN-1:0]  raddr_acc [MASTER_NUM+1];
    logic [ADDR_LEN-1:0]  waddr_acc [MASTER_NUM+1];
    logic [DATA_LEN-1:0]  wdata_acc [MASTER_NUM+1];
    logic [STROB_LEN-1:0] strob_acc [MASTER_NUM+1];
    assign raddr_acc[0] = '0;
    assign waddr_acc[0] = '0;
    assign wdata_acc[0] = '0;
    assign strob_acc[0] = '0;

    for (genvar g = 0; g < MASTER_NUM; g++) begin : g_sel
        assign raddr_acc[g+1] = raddr_acc[g] | (rd_grant[g] ? m_raddr[g*ADDR_LEN +: ADDR_LEN] : '0);
        assign waddr_acc[g+1] = waddr_acc[g] | (wr_grant[g] ? m_waddr[g*ADDR_LEN +: ADDR_LEN] : '0);
        assign wdata_acc[g+1] = wdata_acc[g] | (wr_grant[g] ? m_wdata[g*DATA_LEN +: DATA_LEN] : '0);
        assign strob_acc[g+1] = strob_acc[g] | (wr_grant[g] ? m_strob[g*STROB_LEN +: STROB_LEN] : '0);
    end

`ifdef AXI_BUS_MATRIX_FIXED_PRIO_EN
    assign rd_base = '0;
    assign wr_base = '0;
`else
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW-1:0] rd_nxt_acc [MASTER_NUM+1];
    logic [PW-1:0] wr_nxt_acc [MASTER_NUM+1];
    assign rd_nxt_acc[0] = '0;
    assign wr_nxt_acc[0] = '0;
    for (genvar g = 0; g < MASTER_NUM; g++) begin : g_ptr
        localparam logic [PW-1:0] NEXT = (g == MASTER_NUM - 1) ? '0 : PW'(g + 1);
        assign rd_nxt_acc[g+1] = rd_nxt_acc[g] | (rd_grant[g] ? NEXT : '0);
        assign wr_nxt_acc[g+1] = wr_nxt_acc[g] | (wr_grant[g] ? NEXT : '0);
    end
    assign rd_base = rd_ptr;
    assign wr_base = wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (r_hs) rd_ptr <= rd_nxt_acc[MASTER_NUM];
            if (b_hs) wr_ptr <= wr_nxt_acc[MASTER_NUM];
        end
    end
`endif

    // Read path
    assign s_arvalid = (rd_state == RD_ADDR) && ((m_arvalid & rd_grant) != '0);
    assign m_arready = (rd_state == RD_ADDR) ? (rd_grant & {MASTER_NUM{s_arready}}) : '0;
    assign s_raddr   = raddr_acc[MASTER_NUM];
    assign m_rvalid  = (rd_state == RD_DATA) ? (rd_grant & {MASTER_NUM{s_rvalid}}) : '0;
    assign s_rready  = (rd_state == RD_DATA) && ((m_rready & rd_grant) != '0);
    assign m_rresp   = {MASTER_NUM{s_rresp}};
    assign m_rdata   = {MASTER_NUM{s_rdata}};
    assign r_hs      = s_rvalid && s_rready;

    // Write path; a channel that already handshook is masked until the response completes.
    assign s_awvalid = (wr_state == WR_ADDR) && !aw_done && ((m_awvalid & wr_grant) != '0);
    assign m_awready = (wr_state == WR_ADDR && !aw_done) ? (wr_grant & {MASTER_NUM{s_awready}}) : '0;
    assign s_wvalid  = (wr_state == WR_ADDR) && !w_done && ((m_wvalid & wr_grant) != '0);
    assign m_wready  = (wr_state == WR_ADDR && !w_done) ? (wr_grant & {MASTER_NUM{s_wready}}) : '0;
    assign s_waddr   = waddr_acc[MASTER_NUM];
    assign s_wdata   = wdata_acc[MASTER_NUM];
    assign s_strob   = strob_acc[MASTER_NUM];
    assign m_bvalid  = (wr_state == WR_RESP) ? (wr_grant & {MASTER_NUM{s_bvalid}}) : '0;
    assign s_bready  = (wr_state == WR_RESP) && ((m_bready & wr_grant) != '0);
    assign m_bresp   = {MASTER_NUM{s_bresp}};
    assign aw_hs     = s_awvalid && s_awready;
    assign w_hs      = s_wvalid && s_wready;
    assign b_hs      = s_bvalid && s_bready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
            wr_state <= WR_IDLE;
            rd_grant <= '0;
            wr_grant <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            rd_state <= rd_state_next;
            wr_state <= wr_state_next;
            rd_grant <= rd_grant_next;
            wr_grant <= wr_grant_next;
            if (wr_state == WR_ADDR) begin
                aw_done <= aw_done || aw_hs;
                w_done  <= w_done || w_hs;
            end else if (b_hs) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_state_next = rd_state;
        rd_grant_next = rd_grant;
        case (rd_state)
            RD_IDLE: if (m_arvalid != '0) begin
                rd_grant_next = pick(m_arvalid, rd_base);
                rd_state_next = RD_ADDR;
            end
            RD_ADDR: if (s_arvalid && s_arready) rd_state_next = RD_DATA;
            RD_DATA: if (r_hs) begin
                rd_grant_next = '0;
                rd_state_next = RD_IDLE;
            end
            default: begin
                rd_grant_next = '0;
                rd_state_next = RD_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_state_next = wr_state;
        wr_grant_next = wr_grant;
        case (wr_state)
            WR_IDLE: if ((m_awvalid | m_wvalid) != '0) begin
                wr_grant_next = pick(m_awvalid | m_wvalid, wr_base);
                wr_state_next = WR_ADDR;
            end
            WR_ADDR: if ((aw_done || aw_hs) && (w_done || w_hs)) wr_state_next = WR_RESP;
            WR_RESP: if (b_hs) begin
                wr_grant_next = '0;
                wr_state_next = WR_IDLE;
            end
            default: begin
                wr_grant_next = '0;
                wr_state_next = WR_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_axi_bus_matrix_rr.sv
// tb/tb_axi_bus_matrix_rr.sv - directed self-checking bench for axi_bus_matrix_rr (3 masters)
module tb_axi_bus_matrix_rr;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  m_arvalid, m_arready, m_rvalid, m_rready;
    logic [95:0] m_raddr, m_rdata, m_waddr, m_wdata;
    logic [8:0]  m_rresp, m_bresp;
    logic [2:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [11:0] m_strob;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_raddr, s_rdata, s_waddr, s_wdata;
    logic [2:0]  s_rresp, s_bresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [3:0]  s_strob;
    logic [2:0]  rd_grant, wr_grant;
    int total = 0;
    int bad = 0;

    axi_bus_matrix_rr #(.MASTER_NUM(3), .DATA_LEN(32), .ADDR_LEN(32), .STROB_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_raddr(m_raddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rresp(m_rresp), .m_rdata(m_rdata),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_waddr(m_waddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_strob(m_strob), .m_wdata(m_wdata),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_raddr(s_raddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rresp(s_rresp), .s_rdata(s_rdata),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_waddr(s_waddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_strob(s_strob), .s_wdata(s_wdata),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .rd_grant(rd_grant), .wr_grant(wr_grant)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_arvalid = '0; m_raddr = '0; m_rready = '0;
        m_awvalid = '0; m_waddr = '0; m_wvalid = '0; m_strob = '0; m_wdata = '0; m_bready = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rresp = '0; s_rdata = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        m_arvalid = 3'b111; m_awvalid = 3'b111; m_wvalid = 3'b111;
        s_rvalid = 1'b1; s_bvalid = 1'b1; m_rready = 3'b111; m_bready = 3'b111;
        tick();
        total++; if ({rd_grant, wr_grant} !== 6'b0) begin bad++; $display("FAIL reset_grants got=%b want=000000", {rd_grant, wr_grant}); end
        total++; if ({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready} !== 5'b0) begin bad++; $display("FAIL reset_slave_ctl got=%b want=00000", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}); end
        total++; if ({m_arready, m_rvalid, m_awready, m_wready, m_bvalid} !== 15'b0) begin bad++; $display("FAIL reset_master_ctl got=%b want=0", {m_arready, m_rvalid, m_awready, m_wready, m_bvalid}); end
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_read_contention();
        logic [2:0]  exp_g [3];
        logic [31:0] exp_a [3];
`ifdef AXI_BUS_MATRIX_FIXED_PRIO_EN
        exp_g = '{3'b001, 3'b001, 3'b001};
        exp_a = '{32'h100, 32'h100, 32'h100};
`else
        exp_g = '{3'b001, 3'b010, 3'b100};
        exp_a = '{32'h100, 32'h200, 32'h300};
`endif
        apply_reset();
        m_raddr = {32'h300, 32'h200, 32'h100};
        m_arvalid = 3'b111; m_rready = 3'b111; s_arready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (rd_grant !== exp_g[i]) begin bad++; $display("FAIL contention_grant_%0d got=%b want=%b", i, rd_grant, exp_g[i]); end
            total++; if (s_arvalid !== 1'b1 || s_raddr !== exp_a[i]) begin bad++; $display("FAIL contention_addr_%0d got=%b/%h want=1/%h", i, s_arvalid, s_raddr, exp_a[i]); end
            tick();
            s_rvalid = 1'b1; s_rdata = 32'hA000_0000 + i;
            #1;
            total++; if (m_rvalid !== exp_g[i]) begin bad++; $display("FAIL contention_rvalid_%0d got=%b want=%b", i, m_rvalid, exp_g[i]); end
            tick();
            s_rvalid = 1'b0;
            #1;
            total++; if (rd_grant !== 3'b000 || s_arvalid !== 1'b0) begin bad++; $display("FAIL contention_idle_%0d got=%b/%b want=000/0", i, rd_grant, s_arvalid); end
        end
        m_arvalid = '0;
    endtask

    task automatic test_pointer_wrap();
        apply_reset();
        m_raddr = {32'h300, 32'h200, 32'h100};
        m_arvalid = 3'b100; m_rready = 3'b111; s_arready = 1'b1;
        tick();
        total++; if (rd_grant !== 3'b100) begin bad++; $display("FAIL wrap_first_grant got=%b want=100", rd_grant); end
        tick();
        m_arvalid = '0; s_rvalid = 1'b1;
        tick();
        s_rvalid = 1'b0; m_arvalid = 3'b101;
        tick();
        total++; if (rd_grant !== 3'b001 || s_raddr !== 32'h100) begin bad++; $display("FAIL wrap_second_grant got=%b/%h want=001/100", rd_grant, s_raddr); end
        m_arvalid = '0;
    endtask

    task automatic test_write_w_before_aw();
        int aw_hs = 0;
        int w_hs = 0;
        apply_reset();
        m_wvalid = 3'b010; m_wdata = {32'h0, 32'hDEADBEEF, 32'h0}; m_strob = 12'h0F0;
        s_awready = 1'b1; s_wready = 1'b1;
        #1;
        if (s_wvalid && s_wready) w_hs++;
        if (s_awvalid && s_awready) aw_hs++;
        tick();
        total++; if (wr_grant !== 3'b010) begin bad++; $display("FAIL wfirst_grant got=%b want=010", wr_grant); end
        total++; if (s_wvalid !== 1'b1 || s_wdata !== 32'hDEADBEEF || s_strob !== 4'hF) begin bad++; $display("FAIL wfirst_wdata got=%b/%h/%h want=1/deadbeef/f", s_wvalid, s_wdata, s_strob); end
        total++; if (s_awvalid !== 1'b0 || m_wready !== 3'b010) begin bad++; $display("FAIL wfirst_ctl got=%b/%b want=0/010", s_awvalid, m_wready); end
        if (s_wvalid && s_wready) w_hs++;
        if (s_awvalid && s_awready) aw_hs++;
        tick();
        if (s_wvalid && s_wready) w_hs++;
        if (s_awvalid && s_awready) aw_hs++;
        tick();
        m_awvalid = 3'b010; m_waddr = {32'h0, 32'h80, 32'h0};
        #1;
        total++; if (s_wvalid !== 1'b0 || s_awvalid !== 1'b1 || s_waddr !== 32'h80) begin bad++; $display("FAIL wfirst_aw got=%b/%b/%h want=0/1/80", s_wvalid, s_awvalid, s_waddr); end
        if (s_wvalid && s_wready) w_hs++;
        if (s_awvalid && s_awready) aw_hs++;
        tick();
        m_awvalid = '0; m_wvalid = '0;
        s_bvalid = 1'b1; s_bresp = 3'b010; m_bready = 3'b111;
        #1;
        total++; if (m_bvalid !== 3'b010 || s_bready !== 1'b1) begin bad++; $display("FAIL wfirst_b got=%b/%b want=010/1", m_bvalid, s_bready); end
        total++; if (m_bresp !== 9'b010_010_010) begin bad++; $display("FAIL wfirst_bresp got=%b want=010010010", m_bresp); end
        tick();
        s_bvalid = 1'b0;
        #1;
        total++; if (wr_grant !== 3'b000) begin bad++; $display("FAIL wfirst_release got=%b want=000", wr_grant); end
        total++; if (aw_hs != 1 || w_hs != 1) begin bad++; $display("FAIL wfirst_hs_count got=aw%0d/w%0d want=aw1/w1", aw_hs, w_hs); end
    endtask

    task automatic test_concurrent();
        apply_reset();
        m_arvalid = 3'b001; m_raddr = {32'h0, 32'h0, 32'h40};
        m_awvalid = 3'b100; m_wvalid = 3'b100; m_waddr = {32'h44, 32'h0, 32'h0};
        m_wdata = {32'h5555_AAAA, 32'h0, 32'h0}; m_strob = 12'h300;
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        tick();
        total++; if (rd_grant !== 3'b001 || wr_grant !== 3'b100) begin bad++; $display("FAIL conc_grants got=%b/%b want=001/100", rd_grant, wr_grant); end
        total++; if (s_raddr !== 32'h40 || s_waddr !== 32'h44 || s_wdata !== 32'h5555_AAAA || s_strob !== 4'h3) begin bad++; $display("FAIL conc_payload got=%h/%h/%h/%h want=40/44/5555aaaa/3", s_raddr, s_waddr, s_wdata, s_strob); end
        total++; if (m_arready !== 3'b001 || m_awready !== 3'b100 || m_wready !== 3'b100) begin bad++; $display("FAIL conc_ready got=%b/%b/%b want=001/100/100", m_arready, m_awready, m_wready); end
        tick();
        m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
        s_rvalid = 1'b1; s_bvalid = 1'b1; m_rready = 3'b111; m_bready = 3'b111;
        #1;
        total++; if (m_rvalid !== 3'b001 || m_bvalid !== 3'b100) begin bad++; $display("FAIL conc_resp_route got=%b/%b want=001/100", m_rvalid, m_bvalid); end
        tick();
        s_rvalid = 1'b0; s_bvalid = 1'b0;
        #1;
        total++; if (rd_grant !== 3'b000 || wr_grant !== 3'b000) begin bad++; $display("FAIL conc_release got=%b/%b want=000/000", rd_grant, wr_grant); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        m_arvalid = 3'b001; m_raddr = {32'h0, 32'h0, 32'h10}; s_arready = 1'b1;
        tick();
        tick();
        m_arvalid = '0; s_rvalid = 1'b1; s_rdata = 32'h12345678; m_rready = 3'b000;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (m_rvalid !== 3'b001 || rd_grant !== 3'b001 || s_rready !== 1'b0) begin bad++; $display("FAIL bp_hold_%0d got=%b/%b/%b want=001/001/0", i, m_rvalid, rd_grant, s_rready); end
            total++; if (m_rdata[31:0] !== 32'h12345678) begin bad++; $display("FAIL bp_rdata_%0d got=%h want=12345678", i, m_rdata[31:0]); end
            tick();
        end
        m_rready = 3'b001;
        #1;
        total++; if (s_rready !== 1'b1) begin bad++; $display("FAIL bp_rready got=%b want=1", s_rready); end
        tick();
        s_rvalid = 1'b0;
        #1;
        total++; if (rd_grant !== 3'b000) begin bad++; $display("FAIL bp_release got=%b want=000", rd_grant); end
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        m_arvalid = 3'b001; m_raddr = {32'h0, 32'h222, 32'h111}; s_arready = 1'b1;
        tick();
        tick();
        m_arvalid = '0; s_rvalid = 1'b1; m_rready = 3'b111;
        #1;
        rst_n = 1'b0;
        tick();
        total++; if (rd_grant !== 3'b000 || s_rready !== 1'b0 || m_rvalid !== 3'b000) begin bad++; $display("FAIL midreset_clear got=%b/%b/%b want=000/0/000", rd_grant, s_rready, m_rvalid); end
        rst_n = 1'b1; s_rvalid = 1'b0; m_arvalid = 3'b010;
        tick();
        total++; if (rd_grant !== 3'b010 || s_raddr !== 32'h222) begin bad++; $display("FAIL midreset_regrant got=%b/%h want=010/222", rd_grant, s_raddr); end
        m_arvalid = '0;
    endtask

    initial begin
        test_reset();
        test_read_contention();
        test_pointer_wrap();
        test_write_w_before_aw();
        test_concurrent();
        test_backpressure();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
